// File: rtl/l2_fill_block.sv
// rtl/l2_fill_block.sv - L2 line fill: victim selection (invalid-first / tree PLRU) and one-cycle array write; optional macro L2_FILL_INVALID_FIRST_EN
module l2_fill_block #(
  parameter int INDEX_BITS = 14,
  parameter int LINE_SIZE  = 512,
  parameter int TAG_BITS   = 12,
  parameter int WAYS       = 8,
  localparam int WAY_BITS  = $clog2(WAYS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fill_valid_i,
  output logic                  fill_ready_o,
  input  logic [INDEX_BITS-1:0] fill_index_i,
  input  logic [TAG_BITS-1:0]   fill_tag_i,
  input  logic [LINE_SIZE-1:0]  fill_data_i,
  input  logic                  touch_valid_i,
  input  logic [INDEX_BITS-1:0] touch_index_i,
  input  logic [WAY_BITS-1:0]   touch_way_i,
  output logic                  rd_en_o,
  output logic [INDEX_BITS-1:0] rd_index_o,
  input  logic [WAYS-1:0]       rd_valid_i,
  output logic                  wr_en_o,
  output logic [WAYS-1:0]       wr_way_o,
  output logic [INDEX_BITS-1:0] wr_index_o,
  output logic [TAG_BITS-1:0]   wr_tag_o,
  output logic [LINE_SIZE-1:0]  wr_data_o,
  output logic                  wr_valid_bit_o,
  output logic                  done_o,
  output logic [WAY_BITS-1:0]   done_way_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, SELECT, WRITE} state_t;

  localparam int SETS = 2 ** INDEX_BITS;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [LINE_SIZE-1:0]  data_q, data_d;
  logic [WAY_BITS-1:0]   victim_q, victim_d;

  // Per-set tree bits in heap order; a 0 at a node means the victim lies in its lower half.
  logic [WAYS-2:0]       plru_q [SETS];

  logic [WAYS-2:0]       touch_bits;
  logic [WAYS-2:0]       fill_bits;
  logic [WAY_BITS-1:0]   plru_way;
  logic [WAY_BITS-1:0]   pick_way;

  // Point every node on the path of `way` away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_BITS-1:0] way);
    logic [WAYS-2:0] r;
    int node;
    r = bits;
    node = 0;
    for (int l = WAY_BITS - 1; l >= 0; l--) begin
      r[node] = ~way[l];
      node = 2 * node + 1 + int'(way[l]);
    end
    return r;
  endfunction

  // Follow the tree bits from the root down to a leaf.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_BITS-1:0] v;
    int node;
    v = '0;
    node = 0;
    for (int l = WAY_BITS - 1; l >= 0; l--) begin
      v[l] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
    return v;
  endfunction

  assign plru_way   = plru_victim(plru_q[idx_q]);
  assign touch_bits = plru_touch(plru_q[touch_index_i], touch_way_i);
  // A touch to the set being filled is folded in first so the fill's path wins on shared nodes.
  assign fill_bits  = plru_touch((touch_valid_i && touch_index_i == idx_q) ? touch_bits : plru_q[idx_q],
                                 victim_q);

`ifdef L2_FILL_INVALID_FIRST_EN
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;

  // Lowest-numbered invalid way, if any.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!rd_valid_i[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(i);
      end
    end
  end

  assign pick_way = inv_found ? inv_way : plru_way;
`else
  logic rd_valid_unused;
  assign rd_valid_unused = ^rd_valid_i;
  assign pick_way        = plru_way;
`endif

  assign fill_ready_o = (state_q == IDLE) && !rst_i;

  // Next-state and output decode for the four-step fill sequence.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tag_d          = tag_q;
    data_d         = data_q;
    victim_d       = victim_q;
    rd_en_o        = 1'b0;
    rd_index_o     = '0;
    wr_en_o        = 1'b0;
    wr_way_o       = '0;
    wr_index_o     = '0;
    wr_tag_o       = '0;
    wr_data_o      = '0;
    wr_valid_bit_o = 1'b0;
    done_o         = 1'b0;
    done_way_o     = '0;
    case (state_q)
      IDLE: begin
        if (fill_valid_i) begin
          idx_d   = fill_index_i;
          tag_d   = fill_tag_i;
          data_d  = fill_data_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        rd_en_o    = 1'b1;
        rd_index_o = idx_q;
        state_d    = SELECT;
      end
      SELECT: begin
        victim_d = pick_way;
        state_d  = WRITE;
      end
      WRITE: begin
        wr_en_o        = 1'b1;
        wr_way_o       = WAYS'(1) << victim_q;
        wr_index_o     = idx_q;
        wr_tag_o       = tag_q;
        wr_data_o      = data_q;
        wr_valid_bit_o = 1'b1;
        done_o         = 1'b1;
        done_way_o     = victim_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      victim_q <= victim_d;
    end
  end

  // PLRU storage: touches from the hit path and the fill's own update; the fill write is last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else begin
      if (touch_valid_i) begin
        plru_q[touch_index_i] <= touch_bits;
      end
      if (state_q == WRITE) begin
        plru_q[idx_q] <= fill_bits;
      end
    end
  end

endmodule

// File: tb/tb_l2_fill_block.sv
// tb/tb_l2_fill_block.sv - scoreboard bench for l2_fill_block with a range-halving PLRU reference model
module tb_l2_fill_block;

  localparam int IB = 14;
  localparam int LS = 512;
  localparam int TB_ = 12;
  localparam int WAYS = 8;
  localparam int WB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fill_valid = 1'b0;
  logic          fill_ready;
  logic [IB-1:0] fill_index = '0;
  logic [TB_-1:0] fill_tag = '0;
  logic [LS-1:0] fill_data = '0;
  logic          touch_valid = 1'b0;
  logic [IB-1:0] touch_index = '0;
  logic [WB-1:0] touch_way = '0;
  logic          rd_en;
  logic [IB-1:0] rd_index;
  logic [WAYS-1:0] rd_valid = '0;
  logic          wr_en;
  logic [WAYS-1:0] wr_way;
  logic [IB-1:0] wr_index;
  logic [TB_-1:0] wr_tag;
  logic [LS-1:0] wr_data;
  logic          wr_valid_bit;
  logic          done;
  logic [WB-1:0] done_way;

  l2_fill_block dut (
    .clk_i(clk), .rst_i(rst),
    .fill_valid_i(fill_valid), .fill_ready_o(fill_ready),
    .fill_index_i(fill_index), .fill_tag_i(fill_tag), .fill_data_i(fill_data),
    .touch_valid_i(touch_valid), .touch_index_i(touch_index), .touch_way_i(touch_way),
    .rd_en_o(rd_en), .rd_index_o(rd_index), .rd_valid_i(rd_valid),
    .wr_en_o(wr_en), .wr_way_o(wr_way), .wr_index_o(wr_index), .wr_tag_o(wr_tag),
    .wr_data_o(wr_data), .wr_valid_bit_o(wr_valid_bit),
    .done_o(done), .done_way_o(done_way)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            way;
    logic [IB-1:0] idx;
    logic [TB_-1:0] tag;
    logic [LS-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   obs[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  bit [WAYS-2:0] m_plru [int];
  int            phase = 0;
  logic [IB-1:0] m_idx;
  logic [TB_-1:0] m_tag;
  logic [LS-1:0] m_data;
  int            m_vic;

  task automatic check(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit [WAYS-2:0] get_tree(input int idx);
    if (m_plru.exists(idx)) return m_plru[idx];
    return '0;
  endfunction

  // Descend by halving the way range; a set bit sends the victim to the upper half.
  function automatic int ref_victim(input bit [WAYS-2:0] t);
    int lo = 0, size = WAYS, node = 0;
    while (size > 1) begin
      size = size / 2;
      if (t[node]) begin lo += size; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction

  // Make each node on the way's range path point at the other half.
  function automatic bit [WAYS-2:0] ref_touch(input bit [WAYS-2:0] t, input int way);
    int lo = 0, size = WAYS, node = 0;
    while (size > 1) begin
      size = size / 2;
      if (way >= lo + size) begin t[node] = 1'b0; lo += size; node = 2 * node + 2; end
      else begin t[node] = 1'b1; node = 2 * node + 1; end
    end
    return t;
  endfunction

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] r;
    for (int i = 0; i < LS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model effect of one rising edge, using the inputs held across it.
  task automatic model_edge();
    if (phase == 2) begin
      m_vic = -1;
`ifdef L2_FILL_INVALID_FIRST_EN
      for (int i = 0; i < WAYS; i++) if (m_vic < 0 && !rd_valid[i]) m_vic = i;
`endif
      if (m_vic < 0) m_vic = ref_victim(get_tree(int'(m_idx)));
      sb.push_back('{m_vic, m_idx, m_tag, m_data});
    end
    if (touch_valid) m_plru[int'(touch_index)] = ref_touch(get_tree(int'(touch_index)), int'(touch_way));
    if (phase == 3) m_plru[int'(m_idx)] = ref_touch(get_tree(int'(m_idx)), m_vic);
    if (phase == 0) begin
      if (fill_valid) begin
        m_idx = fill_index; m_tag = fill_tag; m_data = fill_data; phase = 1;
      end
    end else begin
      phase = (phase + 1) % 4;
    end
  endtask

  task automatic step();
    check("fill_ready", fill_ready, phase == 0);
    check("rd_en", rd_en, phase == 1);
    if (phase == 1) check("rd_index", rd_index, m_idx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fill_valid = 1'b0;
    touch_valid = 1'b0;
    #1;
    check("rst_fill_ready", fill_ready, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_wr_valid_bit", wr_valid_bit, 0);
    check("rst_wr_way", wr_way, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done_way", done_way, 0);
    m_plru.delete();
    sb.delete();
    phase = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_fill_ready", fill_ready, 1);
  endtask

  // Issue a fill; optionally touch (tidx, tway) on edge number tph (0 = handshake edge, 3 = write edge).
  task automatic do_fill(input logic [IB-1:0] idx, input logic [TB_-1:0] tag, input int tph,
                         input logic [IB-1:0] tidx, input int tway, input int nsteps);
    fill_valid = 1'b1;
    fill_index = idx;
    fill_tag   = tag;
    fill_data  = rand_line();
    for (int k = 0; k < nsteps; k++) begin
      touch_valid = (k == tph);
      touch_index = tidx;
      touch_way   = WB'(tway);
      step();
      fill_valid = 1'b0;
      fill_index = IB'($urandom);
      fill_tag   = TB_'($urandom);
    end
    touch_valid = 1'b0;
  endtask

  task automatic check_obs(input string name, input int i, input int exp);
    if (i < obs.size()) check(name, obs[i], exp);
    else check({name, "_missing"}, obs.size(), i + 1);
  endtask

  // Monitor: every array write is matched against the oldest expected fill.
  always @(negedge clk) begin
    if (!rst && (wr_en || done)) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_en", wr_en, 1);
        check("done", done, 1);
        check("wr_valid_bit", wr_valid_bit, 1);
        check("wr_way", wr_way, WAYS'(1) << e.way);
        check("done_way", done_way, e.way);
        check("wr_index", wr_index, e.idx);
        check("wr_tag", wr_tag, e.tag);
        check("wr_data", wr_data, e.data);
        obs.push_back(int'(done_way));
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Single fill into an empty set
    rd_valid = 8'h00;
    obs.delete();
    do_fill(14'd5, 12'hABC, -1, '0, 0, 4);
    check_obs("empty_set_way", 0, 0);

    // Full set: pure PLRU rotation
    do_reset();
    rd_valid = 8'hFF;
    obs.delete();
    for (int n = 0; n < 4; n++) do_fill(14'd5, TB_'($urandom), -1, '0, 0, 4);
    check_obs("plru_seq0", 0, 0);
    check_obs("plru_seq1", 1, 4);
    check_obs("plru_seq2", 2, 2);
    check_obs("plru_seq3", 3, 6);

    // One invalid way (way 4)
    do_reset();
    rd_valid = 8'hEF;
    obs.delete();
    do_fill(14'd5, 12'h123, -1, '0, 0, 4);
`ifdef L2_FILL_INVALID_FIRST_EN
    check_obs("invalid_first", 0, 4);
`else
    check_obs("invalid_ignored", 0, 0);
`endif

    // Touch of the same set steers the victim; touch of another set does not
    do_reset();
    rd_valid = 8'hFF;
    obs.delete();
    touch_valid = 1'b1; touch_index = 14'd5; touch_way = 3'd0;
    step();
    touch_valid = 1'b0;
    do_fill(14'd5, 12'h111, -1, '0, 0, 4);
    check_obs("touch_same_set", 0, 4);
    do_reset();
    obs.delete();
    touch_valid = 1'b1; touch_index = 14'd6; touch_way = 3'd0;
    step();
    touch_valid = 1'b0;
    do_fill(14'd5, 12'h222, -1, '0, 0, 4);
    check_obs("touch_other_set", 0, 0);

    // Reset while in SELECT drops the request and clears PLRU
    do_reset();
    do_fill(14'd5, 12'h333, -1, '0, 0, 4);
    obs.delete();
    do_fill(14'd5, 12'h444, -1, '0, 0, 2);
    do_reset();
    check("aborted_fill_writes", obs.size(), 0);
    do_fill(14'd5, 12'h555, -1, '0, 0, 4);
    check_obs("after_abort", 0, 0);

    // Touch of way 4 on the write edge of a way-0 fill: the touch leaves node 2
    // pointing at ways 6-7, the fill then turns the root to the upper half -> way 6.
    do_reset();
    obs.delete();
    do_fill(14'd5, 12'h666, 3, 14'd5, 4, 4);
    do_fill(14'd5, 12'h777, -1, '0, 0, 4);
    check_obs("collide_first", 0, 0);
    check_obs("collide_second", 1, 6);

    // Randomized traffic over a few hot sets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      fill_valid  = ($urandom_range(0, 1) == 1);
      fill_index  = IB'(5 + $urandom_range(0, 2));
      fill_tag    = TB_'($urandom);
      fill_data   = rand_line();
      touch_valid = ($urandom_range(0, 2) == 0);
      touch_index = IB'(5 + $urandom_range(0, 2));
      touch_way   = WB'($urandom_range(0, WAYS - 1));
      rd_valid    = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : 8'hFF;
      step();
    end
    fill_valid = 1'b0;
    touch_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
